cnt_seq_ctrl: RTL
=================

Name: cnt_seq_ctrl

Overview:
- Multi-cycle population-count sequencer: accepts one wide input word through a valid/ready handshake and sums its set bits.
- Time-shares a single narrow Cnt (counter) instance of depth `chunk` over `width/chunk` cycles and accumulates the partial counts.
- Sits between a producer of wide bit-vectors (match masks, flag vectors) and a consumer that needs the popcount when area matters more than latency.

Parameters:
- width, 64, number of input bits per word; must be a multiple of chunk.
- chunk, 16, depth of the shared Cnt instance; must be >1 (Cnt requirement).
- speed, 0, passed to the Cnt instance (0 = linear slices, else tree slices).
- Derived: NCH = width/chunk; CW = log2floor(width)+1 (result width); KW = log2floor(chunk)+1 (partial-count width); IW = max(1, log2floor(NCH-1)+1) (chunk index width).

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  block can accept a word.
- in_data_i  input  width  word to be counted.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- out_count_o  output  CW  number of set bits in the accepted word.
- busy_o  output  1  high while in state RUN.

Behaviour:
- Reset: asserting rst_i immediately forces the following, regardless of clock:
  - state = IDLE; data register, accumulator and index = 0.
  - in_ready_o = 1, out_valid_o = 0, out_count_o = 0, busy_o = 0.
- Reset mid-operation (RUN or DONE) discards the word in flight. No result is produced for it.
- FSM states:
  - IDLE: in_ready_o = 1. When in_valid_i is high at a clock edge:
    - latch in_data_i into the data register;
    - clear the accumulator and index;
    - go to RUN.
    In_data_i is sampled only on that accept edge.
  - RUN: in_ready_o = 0, busy_o = 1. Each cycle:
    - the Cnt instance counts data_reg[idx*chunk +: chunk] combinationally;
    - acc <= acc + zero-extend(partial, to CW bits);
    - idx <= idx + 1.
    On the edge where idx == NCH-1, go to DONE and do not wrap idx.
  - DONE: out_valid_o = 1, out_count_o = acc, held stable until out_ready_i is high at a clock edge. Then go to IDLE and drop out_valid_o.
- Latency: word accepted at edge t gives out_valid_o high after edge t+NCH.
  - Throughput: one word per NCH+2 cycles, because in_ready_o is low in DONE.
  - in_ready_o is purely a function of state; it does not depend on out_ready_i combinationally.
- Width rules:
  - The accumulator is CW bits; the maximum value is width, so it never overflows.
  - The partial count is KW bits, zero-extended before the add.
- Degenerate case NCH == 1: RUN lasts exactly one cycle.
- in_valid_i outside IDLE is ignored: no latching and no error.
- out_ready_i outside DONE is ignored.
- out_count_o holds its last value outside DONE; only its value while out_valid_o is high is specified.
- Handshake rule: out_valid_o, once high, is never withdrawn before out_ready_i, except by reset.

Test Plan:
- width=64, chunk=16; in_data_i = all ones, out_ready_i tied high -> out_valid_o rises 4 cycles after the accept edge, out_count_o = 64 (7'b1000000), out_valid_o high for exactly one cycle.
- in_data_i = 0 -> count 0. Then 64'h8000_0000_0000_0001 -> count 2. Then 64'h00FF_0000_F0F0_0001 -> count 17. in_ready_o is low from the accept edge until the result handshake completes.
- Backpressure: out_ready_i low for 10 cycles in DONE -> out_valid_o and out_count_o stay stable, in_ready_o stays 0, and a new in_valid_i pulse is ignored. After out_ready_i, in_ready_o = 1 next cycle.
- Reset mid-run: rst_i pulsed (between clock edges) during the second RUN cycle -> outputs reset immediately. The next word, 64'hF (count 4), gives count 4 with no trace of the aborted word.
- Parameter sweep, checked against a reference popcount for 1000 random words each:
  - width=18, chunk=6, speed=1 -> latency 3, CW = 5.
  - width=16, chunk=16 (NCH=1) -> latency 1, all-ones gives 16.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_seq_ctrl (with helper module cnt)
//  Purpose  : Multi-cycle popcount sequencer. Accepts a wide word through a
//             valid/ready handshake. It then time-shares one narrow bit counter
//             across WIDTH/CHUNK cycles and accumulates the partial counts.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  cnt : combinational population count of a DEPTH-bit slice.
//        SPEED == 0 uses a linear adder chain. Any other value uses a
//        balanced adder tree.
// ----------------------------------------------------------------------------
module cnt #(
    parameter int DEPTH = 16,
    parameter int SPEED = 0,
    parameter int KW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0] i_data,
    output logic [KW-1:0]    o_count
);

    if (SPEED == 0) begin : g_linear
        // Ripple accumulation, one bit per stage
        always_comb begin
            o_count = '0;
            for (int k = 0; k < DEPTH; k++) begin
                o_count = o_count + KW'(i_data[k]);
            end
        end
    end else begin : g_tree
        // Leaves are padded to a power of two; node[1] is the root
        localparam int LEVELS = $clog2(DEPTH);
        localparam int P2     = 1 << LEVELS;

        logic [KW-1:0] w_node [1:2*P2-1];

        for (genvar i = 0; i < P2; i++) begin : g_leaf
            if (i < DEPTH) begin : g_bit
                assign w_node[P2+i] = KW'(i_data[i]);
            end else begin : g_pad
                assign w_node[P2+i] = '0;
            end
        end

        for (genvar i = 1; i < P2; i++) begin : g_sum
            assign w_node[i] = w_node[2*i] + w_node[2*i+1];
        end

        assign o_count = w_node[1];
    end

endmodule

// ----------------------------------------------------------------------------
//  cnt_seq_ctrl : top-level sequencer
// ----------------------------------------------------------------------------
module cnt_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int SPEED = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$clog2(WIDTH+1)-1:0]   out_count_o,
    output logic                         busy_o
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int KW  = $clog2(CHUNK + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0]    C_ST_IDLE  = 2'd0;
    localparam logic [1:0]    C_ST_RUN   = 2'd1;
    localparam logic [1:0]    C_ST_DONE  = 2'd2;
    localparam logic [IW-1:0] C_LAST_IDX = IW'(NCH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;
    logic [CHUNK-1:0] w_slice;
    logic [KW-1:0]    w_partial;

    // Select the chunk addressed by the current index
    always_comb begin
        w_slice = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == IW'(k)) begin
                w_slice = r_data[k*CHUNK +: CHUNK];
            end
        end
    end

    // Single shared slice counter
    cnt #(
        .DEPTH (CHUNK),
        .SPEED (SPEED),
        .KW    (KW)
    ) u_cnt (
        .i_data  (w_slice),
        .o_count (w_partial)
    );

    // Sequencer FSM: accept, accumulate one chunk per cycle, hold the result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= C_ST_IDLE;
            r_data  <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid_i) begin
                        r_data  <= in_data_i;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= C_ST_RUN;
                    end
                end
                C_ST_RUN: begin
                    r_acc <= r_acc + CW'(w_partial);
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= C_ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                C_ST_DONE: begin
                    if (out_ready_i) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs depend only on state
    assign in_ready_o  = (r_state == C_ST_IDLE);
    assign out_valid_o = (r_state == C_ST_DONE);
    assign busy_o      = (r_state == C_ST_RUN);
    assign out_count_o = r_acc;

endmodule
`default_nettype wire
